// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches the pins, deframes 11-bit frames,
// and folds E0/F0 prefix sequences into a single make (or optional break) event.
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit EMIT_BREAK     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboardCode,
  output logic       ps2_ready,
  output logic       extended,
  output logic       released,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  logic [3:0]    bc_q, bc_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          bv_q, bv_d, bad_q, bad_d;
  state_t        state_q, state_d;
  logic [7:0]    code_q, code_d;
  logic          ext_q, ext_d, rel_q, rel_d, rdy_q, rdy_d, err_q, err_d;

  // Idle-high bus: synchronizers reset to 1 so release from reset never looks like a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  always_comb begin
    fcnt_d = fcnt_q;
    filt_d = filt_q;
    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      fcnt_d = '0;
      filt_d = ~filt_q;
    end else begin
      fcnt_d = fcnt_q + FW'(1);
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    bc_d  = bc_q;
    sh_d  = sh_q;
    par_d = par_q;
    to_d  = to_q;
    bv_d  = 1'b0;
    bad_d = 1'b0;
    if (fall) begin
      to_d = '0;
      case (bc_q)
        4'd0: if (!dat_s2_q) bc_d = 4'd1;
        4'd9: begin
          par_d = dat_s2_q;
          bc_d  = 4'd10;
        end
        4'd10: begin
          bc_d = 4'd0;
          if (dat_s2_q && ((^sh_q) ^ par_q)) bv_d = 1'b1;
          else                               bad_d = 1'b1;
        end
        default: begin
          sh_d = {dat_s2_q, sh_q[7:1]};
          bc_d = bc_q + 4'd1;
        end
      endcase
    end else if (bc_q != 4'd0) begin
      if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bc_d  = 4'd0;
        to_d  = '0;
        bad_d = 1'b1;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  // Errors and valid bytes both go through bv_q/bad_q so ready and frame_err are mutually exclusive.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    if (bad_q) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else if (bv_q) begin
      case (state_q)
        IDLE: begin
          case (sh_q)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = IDLE;
            default: begin
              code_d = sh_q;
              ext_d  = 1'b0;
              rel_d  = 1'b0;
              rdy_d  = 1'b1;
            end
          endcase
        end
        EXT: begin
          if (sh_q == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (sh_q != 8'hE0) begin
            code_d  = sh_q;
            ext_d   = 1'b1;
            rel_d   = 1'b0;
            rdy_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          if (EMIT_BREAK) begin
            code_d = sh_q;
            ext_d  = (state_q == EXT_BRK);
            rel_d  = 1'b1;
            rdy_d  = 1'b1;
          end
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      bc_q    <= 4'd0;
      sh_q    <= 8'h00;
      par_q   <= 1'b0;
      to_q    <= '0;
      bv_q    <= 1'b0;
      bad_q   <= 1'b0;
      state_q <= IDLE;
      code_q  <= 8'h00;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      bc_q    <= bc_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      to_q    <= to_d;
      bv_q    <= bv_d;
      bad_q   <= bad_d;
      state_q <= state_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign keyboardCode = code_q;
  assign extended     = ext_q;
  assign released     = rel_q;
  assign ps2_ready    = rdy_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: two instances (breaks suppressed / emitted) on shared pins,
// checked against a prefix-flag keystroke model plus literal expectations.
module tb_ps2_scan_decoder;

  localparam int FL = 8;
  localparam int TO = 500;
  localparam int H  = 30;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] code0, code1;
  logic       rdy0, rdy1, ext0, ext1, rel0, rel1, err0, err1;

  ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .EMIT_BREAK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboardCode(code0), .ps2_ready(rdy0), .extended(ext0), .released(rel0), .frame_err(err0));

  ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .EMIT_BREAK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboardCode(code1), .ps2_ready(rdy1), .extended(ext1), .released(rel1), .frame_err(err1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  ev_t  q0[$], q1[$];
  int   cyc = 0, vectors = 0, miscompares = 0;
  int   pulses0 = 0, pulses1 = 0, errs0 = 0, rdy_cyc0 = 0, fall_cyc = 0;
  bit   m_ext = 1'b0, m_brk = 1'b0;
  logic [7:0] last_code [2];
  logic       last_ext [2], last_rel [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Keystroke model: prefix flags remembered between bytes; errors wipe them.
  function automatic void model_byte(input logic [7:0] b, input bit ok);
    ev_t e;
    if (!ok) begin
      e = '{1'b1, 8'h00, 1'b0, 1'b0};
      q0.push_back(e);
      q1.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (m_brk) begin
      e = '{1'b0, b, m_ext, 1'b1};
      q1.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!m_ext && (b == 8'hAA || b == 8'hFA || b == 8'hEE ||
                            b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
      m_ext = 1'b0;
    end else begin
      e = '{1'b0, b, m_ext, 1'b0};
      q0.push_back(e);
      q1.push_back(e);
      m_ext = 1'b0;
    end
  endfunction

  task automatic check_one(input int i, input logic r, input logic e, input logic [7:0] c,
                           input logic x, input logic l);
    ev_t exp;
    int  sz;
    if (r && e) begin
      miscompares++;
      $display("FAIL ready_and_err inst%0d: both asserted, required exclusive", i);
    end
    if (r || e) begin
      vectors++;
      sz = (i == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        miscompares++;
        $display("FAIL unexpected_event inst%0d: ready=%0b err=%0b code=%h, required none", i, r, e, c);
      end else begin
        exp = (i == 0) ? q0.pop_front() : q1.pop_front();
        if (e != exp.err || r == exp.err ||
            (!exp.err && (c != exp.code || x != exp.ext || l != exp.rel))) begin
          miscompares++;
          $display("FAIL event inst%0d: got err=%0b code=%h ext=%0b rel=%0b, required err=%0b code=%h ext=%0b rel=%0b",
                   i, e, c, x, l, exp.err, exp.code, exp.ext, exp.rel);
        end
      end
      if (i == 0) begin
        if (r) begin pulses0++; rdy_cyc0 = cyc; end
        if (e) errs0++;
      end else if (r) begin
        pulses1++;
      end
    end
    if (!r && (c != last_code[i] || x != last_ext[i] || l != last_rel[i])) begin
      miscompares++;
      $display("FAIL output_hold inst%0d: got code=%h ext=%0b rel=%0b without ready, required %h/%0b/%0b",
               i, c, x, l, last_code[i], last_ext[i], last_rel[i]);
    end
    last_code[i] = c;
    last_ext[i]  = x;
    last_rel[i]  = l;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        last_code[i] = 8'h00;
        last_ext[i]  = 1'b0;
        last_rel[i]  = 1'b0;
      end
    end else begin
      check_one(0, rdy0, err0, code0, ext0, rel0);
      check_one(1, rdy1, err1, code1, ext1, rel1);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic hold(input int n, input bit lvl, input bit g);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ps2_clk = (g && k >= 15 && k < 18) ? ~lvl : lvl;
    end
  endtask

  task automatic send_bit(input bit v, input bit g);
    @(negedge clk);
    ps2_data = v;
    ps2_clk  = 1'b1;
    hold(H - 1, 1'b1, g);
    @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    hold(H - 1, 1'b0, g);
    @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input bit g);
    model_byte(b, !bad);
    send_bit(1'b0, g);
    for (int k = 0; k < 8; k++) send_bit(b[k], g);
    send_bit((~^b) ^ bad, g);
    send_bit(1'b1, g);
  endtask

  task automatic drained(input string name);
    repeat (60) @(negedge clk);
    chk(name, q0.size() + q1.size(), 0);
  endtask

  initial begin
    int p0, p1, e0;
    repeat (5) @(negedge clk);
    chk("reset_code", {24'h0, code0}, 32'h00);
    chk("reset_flags", {rdy0, ext0, rel0, err0}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b0);
    drained("t1_drain");
    chk("t1_latency", rdy_cyc0 - fall_cyc, FL + 3);
    chk("t1_code", {code0, ext0, rel0}, {8'h1C, 2'b00});
    chk("t1_pulses", pulses0, 1);

    p0 = pulses0;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    drained("t2_drain");
    chk("t2_pulses", pulses0 - p0, 1);
    chk("t2_code", {code0, ext0}, {8'h75, 1'b1});

    p0 = pulses0;
    p1 = pulses1;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    drained("t3_drain");
    chk("t3_pulses_nobrk", pulses0 - p0, 1);
    chk("t3_pulses_brk", pulses1 - p1, 2);
    chk("t3_code", {code0, code1}, {8'h1C, 8'h1C});

    e0 = errs0;
    p0 = pulses0;
    send_frame(8'h1C, 1'b1, 1'b0);
    drained("t4a_drain");
    chk("t4_err", errs0 - e0, 1);
    chk("t4_no_ready", pulses0 - p0, 0);
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    drained("t4b_drain");
    chk("t4_code", {code0, ext0}, {8'h74, 1'b0});

    e0 = errs0;
    model_byte(8'h00, 1'b0);
    for (int k = 0; k < 5; k++) send_bit(k == 0 ? 1'b0 : 1'b1, 1'b0);
    repeat (TO + 50) @(negedge clk);
    drained("t5_drain");
    chk("t5_timeout_err", errs0 - e0, 1);
    send_frame(8'h6B, 1'b0, 1'b0);
    drained("t5b_drain");
    chk("t5_code", {code0, ext0}, {8'h6B, 1'b0});

    p0 = pulses0;
    send_frame(8'h29, 1'b0, 1'b1);
    drained("t6_drain");
    chk("t6_glitch_code", {code0, ext0}, {8'h29, 1'b0});
    chk("t6_pulses", pulses0 - p0, 1);

    for (int k = 0; k < 4; k++) send_bit(k == 0 ? 1'b0 : 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_code", {code0, code1}, 16'h0000);
    chk("rst_flags", {rdy0, ext0, rel0, err0, rdy1, ext1, rel1, err1}, 8'h00);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    q0.delete();
    q1.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0);
    drained("t7_drain");
    chk("t7_code", {code0, ext0}, {8'h5A, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
